// File: rtl/maxpool_ctrl.sv
// ---------------------------------------------------------------------------
// maxpool_ctrl
//
// Streaming 2x2, stride-2 max-pooling engine for unsigned DATA_W-bit pixels.
// Pixels arrive in row-major order over a valid/ready handshake. Each
// horizontal pair is reduced to one value. On even rows that value is parked
// in a line buffer. On odd rows it is merged with the parked value to form one
// pooled output. A trailing odd column or a final odd row is accepted and then
// dropped.
//
// Parameters
//   DATA_W  pixel width in bits
//   MAX_W   largest feature-map width (even, <= 254); wider configs are clamped
//
// Ports
//   clk         clock, rising edge
//   rst         asynchronous active-high reset
//   start       one-cycle pulse; latches cfg_* and starts a job (IDLE only)
//   cfg_width   feature-map width in pixels
//   cfg_height  feature-map height in pixels
//   in_valid    input pixel valid
//   in_ready    input pixel accepted when in_valid && in_ready
//   in_data     input pixel
//   out_valid   pooled result valid
//   out_ready   downstream accepts when out_valid && out_ready
//   out_data    pooled 2x2 maximum, held stable while stalled
//   busy        high while a job is in progress
//   done        one-cycle pulse when a job completes
// ---------------------------------------------------------------------------
module maxpool_ctrl #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned MAX_W  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        cfg_width,
  input  logic [7:0]        cfg_height,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done
);

  // One line-buffer entry per horizontal pair. Guard tiny MAX_W values so the
  // array and its index never collapse to zero width.
  localparam int unsigned LbDepth = (MAX_W >= 4) ? (MAX_W / 2) : 1;
  localparam int unsigned LbAw    = (LbDepth > 1) ? $clog2(LbDepth) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFlush
  } state_e;

  function automatic logic [DATA_W-1:0] umax(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
    return (a >= b) ? a : b;
  endfunction

  // State registers and their next-state values.
  state_e            state_q, state_d;
  logic [7:0]        width_q, width_d;
  logic [7:0]        height_q, height_d;
  logic [7:0]        col_q, col_d;
  logic [7:0]        row_q, row_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;

  // Line buffer: no reset needed, every entry is written on an even row
  // before it is read on the following odd row.
  logic [DATA_W-1:0] line_buf_q [LbDepth];
  logic              lb_we;
  logic [LbAw-1:0]   lb_idx;
  logic [DATA_W-1:0] lb_rdata;
  logic [DATA_W-1:0] lb_wdata;

  logic              accept;
  logic              last_col;
  logic              last_row;
  logic [DATA_W-1:0] pair_max;

  // Pair index is col/2; MAX_W <= 254 keeps it inside col_q.
  assign lb_idx   = col_q[LbAw:1];
  assign lb_rdata = line_buf_q[lb_idx];
  assign pair_max = umax(hold_q, in_data);
  assign last_col = (col_q == width_q - 8'd1);
  assign last_row = (row_q == height_q - 8'd1);

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  // Next-state and output logic.
  always_comb begin
    state_d     = state_q;
    width_d     = width_q;
    height_d    = height_q;
    col_d       = col_q;
    row_d       = row_q;
    hold_d      = hold_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    lb_we       = 1'b0;
    lb_wdata    = pair_max;
    done        = 1'b0;
    busy        = (state_q != StIdle);

    // A stalled result blocks input so nothing can overwrite it.
    in_ready = (state_q == StRun) && !(out_valid_q && !out_ready);
    accept   = in_valid && in_ready;

    // Result leaves on handshake; a new load below takes priority.
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          width_d  = (32'(cfg_width) > MAX_W) ? 8'(MAX_W) : cfg_width;
          height_d = cfg_height;
          col_d    = 8'd0;
          row_d    = 8'd0;
          // Degenerate maps produce nothing: pass straight through FLUSH.
          if ((width_d < 8'd2) || (height_d < 8'd2)) begin
            state_d = StFlush;
          end else begin
            state_d = StRun;
          end
        end
      end

      StRun: begin
        if (accept) begin
          if (!col_q[0]) begin
            hold_d = in_data;
          end else if (!row_q[0]) begin
            lb_we = 1'b1;
          end else begin
            out_valid_d = 1'b1;
            out_data_d  = umax(pair_max, lb_rdata);
          end

          if (last_col) begin
            col_d = 8'd0;
            row_d = row_q + 8'd1;
          end else begin
            col_d = col_q + 8'd1;
          end

          if (last_col && last_row) begin
            state_d = StFlush;
          end
        end
      end

      StFlush: begin
        // Finish only once the last result has been taken downstream.
        if (!out_valid_q) begin
          done    = 1'b1;
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      width_q     <= 8'd0;
      height_q    <= 8'd0;
      col_q       <= 8'd0;
      row_q       <= 8'd0;
      hold_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      width_q     <= width_d;
      height_q    <= height_d;
      col_q       <= col_d;
      row_q       <= row_d;
      hold_q      <= hold_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (lb_we) begin
      line_buf_q[lb_idx] <= lb_wdata;
    end
  end

endmodule

// File: tb/tb_maxpool_ctrl.sv
// ---------------------------------------------------------------------------
// tb_maxpool_ctrl
//
// Directed bench for maxpool_ctrl. Each job queues its hand-computed pooled
// results before stimulus starts; a negedge monitor pops and compares on
// every output handshake, checks that stalled results hold, and counts
// accepted pixels and done pulses.
// ---------------------------------------------------------------------------
module tb_maxpool_ctrl;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned MAX_W  = 64;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [7:0]        cfg_width = 8'd0;
  logic [7:0]        cfg_height = 8'd0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [DATA_W-1:0] out_data;
  logic              busy;
  logic              done;

  int total = 0;
  int bad = 0;
  int acc_cnt = 0;
  int done_cnt = 0;

  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] pix_q[$];

  maxpool_ctrl #(
    .DATA_W(DATA_W),
    .MAX_W (MAX_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cfg_width (cfg_width),
    .cfg_height(cfg_height),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, want);
    end
  endtask

  // Monitor: samples mid-cycle, so handshakes seen here complete at the next
  // rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready) acc_cnt++;
      if (done) done_cnt++;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", int'(out_data), -1);
        end else if (out_ready) begin
          check("out_data", int'(out_data), int'(exp_q.pop_front()));
        end else begin
          check("stall_hold", int'(out_data), int'(exp_q[0]));
          check("stall_in_ready", int'(in_ready), 0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [7:0] w, input logic [7:0] h);
    start      = 1'b1;
    cfg_width  = w;
    cfg_height = h;
    tick();
    start = 1'b0;
  endtask

  // Offers pix_q in order, advancing only on accepted handshakes.
  task automatic feed();
    int  i = 0;
    int  guard = 0;
    logic acc;
    while (i < pix_q.size() && guard < 3000) begin
      in_valid = 1'b1;
      in_data  = pix_q[i];
      @(negedge clk);
      acc = in_ready;
      tick();
      if (acc) i++;
      guard++;
    end
    in_valid = 1'b0;
    check("feed_complete", i, pix_q.size());
  endtask

  task automatic finish_job(input string name, input int acc_base, input int done_base,
                            input int n_pix);
    int n = 0;
    while (done_cnt == done_base && n < 200) begin
      tick();
      n++;
    end
    repeat (3) tick();
    check({name, "_done"}, done_cnt - done_base, 1);
    check({name, "_accepted"}, acc_cnt - acc_base, n_pix);
    check({name, "_left"}, exp_q.size(), 0);
  endtask

  task automatic release_stall();
    int n = 0;
    while (!out_valid && n < 200) begin
      tick();
      n++;
    end
    repeat (8) tick();
    out_ready = 1'b1;
  endtask

  initial begin
    int ab;
    int db;

    // Reset state.
    repeat (3) tick();
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_out_data", int'(out_data), 0);
    rst = 1'b0;
    tick();

    // 4x4 ramp, free-flowing output.
    ab = acc_cnt; db = done_cnt;
    exp_q = '{8'd5, 8'd7, 8'd13, 8'd15};
    pix_q.delete();
    for (int i = 0; i < 16; i++) pix_q.push_back(8'(i));
    start_job(8'd4, 8'd4);
    check("t1_busy", int'(busy), 1);
    feed();
    finish_job("t1", ab, db, 16);

    // Same map with the first result stalled.
    ab = acc_cnt; db = done_cnt;
    exp_q = '{8'd5, 8'd7, 8'd13, 8'd15};
    out_ready = 1'b0;
    start_job(8'd4, 8'd4);
    fork
      feed();
      release_stall();
    join
    finish_job("t2", ab, db, 16);

    // 5x3: odd column and odd row are dropped.
    ab = acc_cnt; db = done_cnt;
    exp_q = '{8'd6, 8'd8};
    pix_q.delete();
    for (int i = 0; i < 15; i++) pix_q.push_back(8'(i));
    start_job(8'd5, 8'd3);
    feed();
    finish_job("t3", ab, db, 15);

    // 2x2 unsigned compare.
    ab = acc_cnt; db = done_cnt;
    exp_q = '{8'd255};
    pix_q = '{8'd0, 8'd255, 8'd128, 8'd1};
    start_job(8'd2, 8'd2);
    feed();
    finish_job("t4", ab, db, 4);

    // Reset in row 1 with a stalled result pending.
    exp_q = '{8'd5};
    pix_q.delete();
    for (int i = 0; i < 6; i++) pix_q.push_back(8'(i));
    out_ready = 1'b0;
    start_job(8'd4, 8'd4);
    feed();
    check("t5_pre_valid", int'(out_valid), 1);
    check("t5_pre_data", int'(out_data), 5);
    rst = 1'b1;
    #1;
    check("t5_rst_valid", int'(out_valid), 0);
    check("t5_rst_busy", int'(busy), 0);
    check("t5_rst_in_ready", int'(in_ready), 0);
    check("t5_rst_data", int'(out_data), 0);
    exp_q.delete();
    tick();
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    ab = acc_cnt; db = done_cnt;
    exp_q = '{8'd9};
    pix_q = '{8'd3, 8'd9, 8'd7, 8'd2};
    start_job(8'd2, 8'd2);
    check("t5_restart_busy", int'(busy), 1);
    feed();
    finish_job("t5", ab, db, 4);

    // Start while busy is ignored.
    ab = acc_cnt; db = done_cnt;
    exp_q = '{8'd40};
    pix_q = '{8'd10, 8'd20, 8'd30, 8'd40};
    start_job(8'd2, 8'd2);
    start_job(8'd1, 8'd1);
    check("t6_busy", int'(busy), 1);
    feed();
    finish_job("t6", ab, db, 4);

    // Degenerate width: done one cycle after start, nothing consumed.
    ab = acc_cnt; db = done_cnt;
    in_valid = 1'b1;
    in_data  = 8'd77;
    start_job(8'd1, 8'd4);
    check("t7_done", int'(done), 1);
    check("t7_busy", int'(busy), 1);
    check("t7_in_ready", int'(in_ready), 0);
    tick();
    check("t7_done_after", int'(done), 0);
    check("t7_busy_after", int'(busy), 0);
    repeat (3) tick();
    in_valid = 1'b0;
    check("t7_done_count", done_cnt - db, 1);
    check("t7_accepted", acc_cnt - ab, 0);

    // Width 200 clamps to MAX_W; row 0 ramps, row 1 zeros.
    ab = acc_cnt; db = done_cnt;
    exp_q.delete();
    pix_q.delete();
    for (int k = 0; k < 32; k++) exp_q.push_back(8'(2 * k + 1));
    for (int c = 0; c < 64; c++) pix_q.push_back(8'(c));
    for (int c = 0; c < 64; c++) pix_q.push_back(8'd0);
    start_job(8'd200, 8'd2);
    feed();
    finish_job("t8", ab, db, 128);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/maxpool_ctrl.md
MAXPOOL_CTRL -- requirements
Module: maxpool_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8, pixel width (unsigned Qint8).
REQ-002 SHALL have parameter MAX_W, default 64, maximum feature-map width (even).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  one-cycle pulse; latches config and begins a pooling job.
REQ-006 SHALL have port cfg_width  input  8  feature-map width in pixels.
REQ-007 SHALL have port cfg_height  input  8  feature-map height in pixels.
REQ-008 SHALL have port in_valid  input  1  input pixel valid.
REQ-009 SHALL have port in_ready  output  1  input pixel accepted when in_valid && in_ready.
REQ-010 SHALL have port in_data  input  DATA_W  input pixel, row-major order.
REQ-011 SHALL have port out_valid  output  1  pooled result valid.
REQ-012 SHALL have port out_ready  input  1  downstream accepts when out_valid && out_ready.
REQ-013 SHALL have port out_data  output  DATA_W  pooled 2x2 maximum.
REQ-014 SHALL have port busy  output  1  high from cycle after accepted start until done.
REQ-015 SHALL have port done  output  1  one-cycle pulse at job completion.

Function
REQ-016 SHALL implement 2x2 window, stride 2, max pooling; comparison unsigned; ties keep either (equal) value.
REQ-017 SHALL use FSM states IDLE, RUN, FLUSH; IDLE->RUN on start, RUN->FLUSH after last input pixel accepted, FLUSH->IDLE when output register empty; done pulses on FLUSH->IDLE.
REQ-018 SHALL latch cfg_width/cfg_height on start in IDLE; start while not IDLE SHALL be ignored.
REQ-019 SHALL, if latched width<2 or height<2, go IDLE->FLUSH->IDLE with done one cycle after start, consuming no input and producing no output.
REQ-020 SHALL clamp latched width to MAX_W when cfg_width>MAX_W.
REQ-021 SHALL track column and row counters; column wraps to 0 and row increments on last pixel of a row.
REQ-022 SHALL hold a pair register: on even column store pixel; on odd column form pair_max=max(held,pixel).
REQ-023 SHALL on even rows write pair_max into line buffer entry col/2 (MAX_W/2 entries).
REQ-024 SHALL on odd rows compute max(pair_max, line_buffer[col/2]) and load it into the output register.
REQ-025 SHALL present a result with out_valid the cycle after the accepting odd-row odd-column pixel handshake (latency 1).
REQ-026 SHALL floor odd dimensions: trailing odd column pixels and final odd row pixels are accepted and discarded.
REQ-027 SHALL drive in_ready = (state==RUN) && !(out_valid && !out_ready); no input lost or duplicated under backpressure.
REQ-028 SHALL hold out_data stable while out_valid && !out_ready.
REQ-029 SHALL total width*height accepted pixels and floor(w/2)*floor(h/2) outputs per job.

Reset
REQ-030 SHALL on rst force state IDLE, counters 0, out_valid 0, in_ready 0, busy 0, done 0, out_data 0 immediately.
REQ-031 SHALL abandon a job on reset mid-operation with no further output; line buffer contents need not be reset.
REQ-032 SHALL accept a new start on the first clock edge after rst deasserts.

Verification
REQ-033 4x4 map, pixels 0..15 row-major, out_ready=1 -> outputs 5,7,13,15 in order, then done pulse.
REQ-034 Same 4x4 map, out_ready held 0 after first output -> out_data stays 5, in_ready low, no pixels lost; releasing out_ready yields 7,13,15.
REQ-035 5x3 map, pixels 0..14 -> 15 pixels accepted, outputs 6,8 only, done.
REQ-036 2x2 map {0,255,128,1} -> single output 255 (unsigned compare).
REQ-037 rst asserted mid-job in row 1 -> out_valid/busy low same cycle; new 2x2 job after reset produces correct result.
REQ-038 start while busy, and start with cfg_width=1 -> ignored; degenerate job gives done one cycle after start, no output.
